// File: rtl/seg_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner.
package seg_pkg;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned IdxW   = $clog2(DIGITS);

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StGap
  } state_e;

  // Segment patterns {g,f,e,d,c,b,a} for hex 0..F; element i is the code for nibble i.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // True when digit idx (idx >= 1) and every digit above it hold a zero nibble.
  function automatic logic lead_zero(logic [DIGITS*4-1:0] data, logic [IdxW-1:0] idx);
    logic all_zero;
    all_zero  = 1'b1;
    lead_zero = 1'b0;
    if (idx != '0) begin
      for (int j = 0; j < int'(DIGITS); j++) begin
        if (j >= int'(idx) && data[4*j +: 4] != 4'h0) all_zero = 1'b0;
      end
      lead_zero = all_zero;
    end
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host-side and display-side signals of the segment scanner.
interface seg_scan_ctrl_if;
  import seg_pkg::*;

  logic                  en_i;
  logic                  load_i;
  logic [DIGITS*4-1:0]   data_i;
  logic [DIGITS-1:0]     dp_i;
  logic [DIGITS-1:0]     blank_i;
  logic [DIGITS-1:0]     ds;
  logic [7:0]            seg;
  logic                  frame_o;

  modport master (
    output en_i, load_i, data_i, dp_i, blank_i,
    input  ds, seg, frame_o
  );

  modport slave (
    input  en_i, load_i, data_i, dp_i, blank_i,
    output ds, seg, frame_o
  );
endinterface

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to seven-segment {g,f,e,d,c,b,a} decoder.
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed eight-digit seven-segment scan controller with dead-time between digits.
// Optional SEG_LEADZERO_EN: darkens leading zero digits (7..1), keeping their decimal point.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter int unsigned GAP_CYCLES = 4
) (
  input logic             clk,
  input logic             rst_n,
  seg_scan_ctrl_if.slave  bus
);

  localparam int unsigned    CntW    = 20;
  localparam logic [CntW-1:0] OnLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 load_cur;
  logic                 wrap;

  logic [DIGITS*4-1:0]  data_sh_q;
  logic [DIGITS-1:0]    dp_sh_q;
  logic [DIGITS-1:0]    blank_sh_q;

  logic [3:0]           nib_q;
  logic                 dp_q;
  logic                 blank_q;
  logic                 lz_q;
  logic                 lz_d;

  logic [DIGITS-1:0]    ds_q;
  logic [7:0]           seg_q;
  logic                 frame_q;
  logic [6:0]           hex_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh_q  <= '0;
      dp_sh_q    <= '0;
      blank_sh_q <= '0;
    end else if (bus.load_i) begin
      data_sh_q  <= bus.data_i;
      dp_sh_q    <= bus.dp_i;
      blank_sh_q <= bus.blank_i;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    load_cur = 1'b0;
    wrap     = 1'b0;
    if (!bus.en_i) begin
      state_d = StIdle;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StOn;
          cnt_d    = '0;
          load_cur = 1'b1;
        end
        StOn: begin
          if (cnt_q == OnLast) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            wrap  = (idx_q == IdxW'(DIGITS - 1));
            if (GAP_CYCLES == 0) begin
              state_d  = StOn;
              load_cur = 1'b1;
            end else begin
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StGap: begin
          if (cnt_q == GapLast) begin
            state_d  = StOn;
            cnt_d    = '0;
            load_cur = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

`ifdef SEG_LEADZERO_EN
  assign lz_d = lead_zero(data_sh_q, idx_d);
`else
  assign lz_d = 1'b0;
`endif

  // Digit content is frozen at ON entry so mid-phase loads only affect later digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q   <= '0;
      dp_q    <= 1'b0;
      blank_q <= 1'b0;
      lz_q    <= 1'b0;
    end else if (load_cur) begin
      nib_q   <= data_sh_q[{idx_d, 2'b00} +: 4];
      dp_q    <= dp_sh_q[idx_d];
      blank_q <= blank_sh_q[idx_d];
      lz_q    <= lz_d;
    end
  end

  seg_hex_dec u_hex_dec (
    .nib (nib_q),
    .seg (hex_seg)
  );

  // Outputs trail the state by one cycle, so each digit is driven for exactly CLK_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_q    <= '1;
      seg_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= wrap;
      if (state_q == StOn) begin
        ds_q <= ~(DIGITS'(1) << idx_q);
        if (blank_q)   seg_q <= '0;
        else if (lz_q) seg_q <= {7'b0, dp_q};
        else           seg_q <= {hex_seg, dp_q};
      end else begin
        ds_q  <= '1;
        seg_q <= '0;
      end
    end
  end

  assign bus.ds      = ds_q;
  assign bus.seg     = seg_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4, GAP_CYCLES=1 (5 cycles per digit, 40 per frame).
module tb_seg_scan_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .CLK_DIV    (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] hex_code(logic [3:0] n);
    case (n)
      4'h0: hex_code = 7'b0111111;
      4'h1: hex_code = 7'b0000110;
      4'h2: hex_code = 7'b1011011;
      4'h3: hex_code = 7'b1001111;
      4'h4: hex_code = 7'b1100110;
      4'h5: hex_code = 7'b1101101;
      4'h6: hex_code = 7'b1111101;
      4'h7: hex_code = 7'b0000111;
      4'h8: hex_code = 7'b1111111;
      4'h9: hex_code = 7'b1101111;
      4'hA: hex_code = 7'b1110111;
      4'hB: hex_code = 7'b1111100;
      4'hC: hex_code = 7'b0111001;
      4'hD: hex_code = 7'b1011110;
      4'hE: hex_code = 7'b1111001;
      default: hex_code = 7'b1110001;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(logic [31:0] d, logic [7:0] dp, logic [7:0] bl, int k);
    logic [3:0] nib;
    logic       lz;
    nib = d[4*k +: 4];
    lz  = 1'b0;
`ifdef SEG_LEADZERO_EN
    if (k > 0) begin
      lz = 1'b1;
      for (int j = k; j < 8; j++) if (d[4*j +: 4] != 4'h0) lz = 1'b0;
    end
`endif
    if (bl[k])   exp_seg = 8'h00;
    else if (lz) exp_seg = {7'b0, dp[k]};
    else         exp_seg = {hex_code(nib), dp[k]};
  endfunction

  // Starts at the first visible cycle of digit k: 4 lit cycles, then 1 dark gap cycle.
  task automatic expect_digit(input int k, input logic [31:0] d, input logic [7:0] dp,
                              input logic [7:0] bl, input bit ld, input logic [31:0] nd);
    logic [7:0] ds_exp;
    ds_exp = ~(8'h01 << k);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ds d%0d c%0d", k, i), bus.ds, ds_exp);
      check_eq($sformatf("seg d%0d c%0d", k, i), bus.seg, exp_seg(d, dp, bl, k));
      check_eq($sformatf("frame d%0d c%0d", k, i), bus.frame_o, (k == 7 && i == 3));
      if (ld && i == 1) begin
        bus.load_i = 1'b1;
        bus.data_i = nd;
      end
      step();
      bus.load_i = 1'b0;
    end
    check_eq($sformatf("gap ds d%0d", k), bus.ds, 8'hFF);
    check_eq($sformatf("gap seg d%0d", k), bus.seg, 8'h00);
    check_eq($sformatf("gap frame d%0d", k), bus.frame_o, 1'b0);
    step();
  endtask

  // Drop to idle, load shadows, re-enable; returns at the first visible cycle of digit 0.
  task automatic restart(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
    bus.en_i    = 1'b0;
    bus.load_i  = 1'b1;
    bus.data_i  = d;
    bus.dp_i    = dp;
    bus.blank_i = bl;
    step();
    bus.load_i = 1'b0;
    step();
    step();
    check_eq("idle ds", bus.ds, 8'hFF);
    check_eq("idle seg", bus.seg, 8'h00);
    bus.en_i = 1'b1;
    step();
    check_eq("entry ds", bus.ds, 8'hFF);
    step();
  endtask

  initial begin
    bus.en_i    = 1'b0;
    bus.load_i  = 1'b0;
    bus.data_i  = '0;
    bus.dp_i    = '0;
    bus.blank_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst ds", bus.ds, 8'hFF);
    check_eq("rst seg", bus.seg, 8'h00);
    check_eq("rst frame", bus.frame_o, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Full scan, two frames back to back
    restart(32'h76543210, 8'h00, 8'h00);
    check_eq("digit0 code", bus.seg, 8'b01111110);
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 8; k++) expect_digit(k, 32'h76543210, 8'h00, 8'h00, 1'b0, '0);

    // Leading zeros (suppressed only when the macro is defined)
    restart(32'h000000A5, 8'h00, 8'h00);
    expect_digit(0, 32'h000000A5, 8'h00, 8'h00, 1'b0, '0);
    check_eq("digit1 A code", bus.seg, 8'b11101110);
    for (int k = 1; k < 8; k++) expect_digit(k, 32'h000000A5, 8'h00, 8'h00, 1'b0, '0);

    // Blank digit 2, decimal point on digit 0
    restart(32'h76543210, 8'h01, 8'h04);
    check_eq("dp digit0", bus.seg[0], 1'b1);
    for (int k = 0; k < 8; k++) expect_digit(k, 32'h76543210, 8'h01, 8'h04, 1'b0, '0);

    // Load during digit 3 only takes effect from digit 4
    restart(32'h76543210, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) expect_digit(k, 32'h76543210, 8'h00, 8'h00, 1'b0, '0);
    expect_digit(3, 32'h76543210, 8'h00, 8'h00, 1'b1, 32'hFEDCBA98);
    expect_digit(4, 32'hFEDCBA98, 8'h00, 8'h00, 1'b0, '0);

    // Asynchronous reset in the middle of digit 5
    check_eq("digit5 ds", bus.ds, 8'hDF);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst ds", bus.ds, 8'hFF);
    check_eq("midrst seg", bus.seg, 8'h00);
    check_eq("midrst frame", bus.frame_o, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_eq("release ds", bus.ds, 8'hFF);
    step();
    expect_digit(0, 32'h0, 8'h00, 8'h00, 1'b0, '0);
    expect_digit(1, 32'h0, 8'h00, 8'h00, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
